// File: rtl/operand_fetch_2r_if.sv
// Bundle for the operand-fetch stage: the request side, both bank read
// ports, the write-port snoop and the operand output.
interface operand_fetch_2r_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4,
  parameter int TAG_WIDTH  = 6
);
  localparam int W = NB_COL * COL_WIDTH;

  // Request side
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_address1;
  logic [ADDR_WIDTH-1:0] req_address2;
  logic [TAG_WIDTH-1:0]  req_tag;

  // Bank read ports
  logic                  read1_enable;
  logic [ADDR_WIDTH-1:0] read1_address;
  logic [W-1:0]          read1_data;
  logic                  read2_enable;
  logic [ADDR_WIDTH-1:0] read2_address;
  logic [W-1:0]          read2_data;

  // Snoop of the bank write port
  logic [NB_COL-1:0]     write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [W-1:0]          write_data;

  // Operand output
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data1;
  logic [W-1:0]          out_data2;
  logic [TAG_WIDTH-1:0]  out_tag;

  // The fetch stage itself.
  modport slave (
    input  req_valid, req_address1, req_address2, req_tag,
    input  read1_data, read2_data,
    input  write_enable, write_address, write_data,
    input  out_ready,
    output req_ready,
    output read1_enable, read1_address, read2_enable, read2_address,
    output out_valid, out_data1, out_data2, out_tag
  );

  // Requester, bank and consumer seen together.
  modport master (
    output req_valid, req_address1, req_address2, req_tag,
    output read1_data, read2_data,
    output write_enable, write_address, write_data,
    output out_ready,
    input  req_ready,
    input  read1_enable, read1_address, read2_enable, read2_address,
    input  out_valid, out_data1, out_data2, out_tag
  );
endinterface

// File: rtl/operand_fetch_2r.sv
// Read-issue and operand-hold stage in front of a write-first 2R1W bank.
// One entry deep: reads issue on accept, operands appear one cycle later,
// and while the consumer stalls the held operands absorb snooped writes so
// they always match the bank contents.
module operand_fetch_2r #(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4,
  parameter int TAG_WIDTH  = 6
) (
  input logic              clock,
  input logic              resetn,
  operand_fetch_2r_if.slave bus
);
  localparam int W = NB_COL * COL_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing outstanding
    FRESH = 2'd1,  // operands arriving straight from the bank this cycle
    HELD  = 2'd2   // consumer stalled, operands live in hold registers
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [W-1:0]          hold1_q, hold1_d;
  logic [W-1:0]          hold2_q, hold2_d;

  logic out_valid;
  logic req_ready;
  logic accept;

  // Overlay the snooped write onto a word, column by column, when the write
  // targets the address this operand was fetched from.
  function automatic logic [W-1:0] merge_write(
    input logic [W-1:0]          src,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [NB_COL-1:0]     wen,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [W-1:0]          wdata
  );
    logic [W-1:0] res;
    res = src;
    if (waddr == addr) begin
      for (int c = 0; c < NB_COL; c++) begin
        if (wen[c]) res[c*COL_WIDTH +: COL_WIDTH] = wdata[c*COL_WIDTH +: COL_WIDTH];
      end
    end
    return res;
  endfunction

  // Handshake: the single slot frees up whenever the consumer takes it.
  always_comb begin
    out_valid = (state_q != EMPTY);
    req_ready = !out_valid || bus.out_ready;
    accept    = bus.req_valid && req_ready;
  end

  // Bank reads issue combinationally on accept and never while in reset.
  assign bus.req_ready     = req_ready;
  assign bus.read1_enable  = accept && resetn;
  assign bus.read2_enable  = accept && resetn;
  assign bus.read1_address = bus.req_address1;
  assign bus.read2_address = bus.req_address2;
  assign bus.out_valid     = out_valid;
  assign bus.out_tag       = tag_q;

  // Next-state, request capture and hold/merge logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    tag_d   = tag_q;
    hold1_d = hold1_q;
    hold2_d = hold2_q;

    if (accept) begin
      addr1_d = bus.req_address1;
      addr2_d = bus.req_address2;
      tag_d   = bus.req_tag;
    end

    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FRESH;
      end
      FRESH: begin
        if (bus.out_ready) begin
          state_d = accept ? FRESH : EMPTY;
        end else begin
          // Stall: bank data is only valid this cycle, so capture it now,
          // folding in any write landing in this same cycle.
          hold1_d = merge_write(bus.read1_data, addr1_q, bus.write_enable,
                                bus.write_address, bus.write_data);
          hold2_d = merge_write(bus.read2_data, addr2_q, bus.write_enable,
                                bus.write_address, bus.write_data);
          state_d = HELD;
        end
      end
      HELD: begin
        if (bus.out_ready) begin
          state_d = accept ? FRESH : EMPTY;
        end else begin
          hold1_d = merge_write(hold1_q, addr1_q, bus.write_enable,
                                bus.write_address, bus.write_data);
          hold2_d = merge_write(hold2_q, addr2_q, bus.write_enable,
                                bus.write_address, bus.write_data);
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Operand mux: bank data in the cycle after issue, hold registers after.
  always_comb begin
    bus.out_data1 = '0;
    bus.out_data2 = '0;
    unique case (state_q)
      FRESH: begin
        bus.out_data1 = bus.read1_data;
        bus.out_data2 = bus.read2_data;
      end
      HELD: begin
        bus.out_data1 = hold1_q;
        bus.out_data2 = hold2_q;
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: the hold words are ordinary registers, not a memory array, so
    // they are cleared on reset along with the rest of the state.
    if (!resetn) begin
      state_q <= EMPTY;
      addr1_q <= '0;
      addr2_q <= '0;
      tag_q   <= '0;
      hold1_q <= '0;
      hold2_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      tag_q   <= tag_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
    end
  end
endmodule

// File: tb/tb_operand_fetch_2r.sv
// Bench for operand_fetch_2r: write-first 2R1W bank model, table of
// streaming vectors, hand-written stall/merge/reset sequences, and a
// scoreboard of expected operands checked on every output handshake.
module tb_operand_fetch_2r;
  localparam int SIZE = 1024;
  localparam int AW   = 10;
  localparam int COLW = 8;
  localparam int NCOL = 4;
  localparam int TW   = 6;
  localparam int W    = NCOL * COLW;

  logic clock;
  logic resetn;

  operand_fetch_2r_if #(.ADDR_WIDTH(AW), .COL_WIDTH(COLW), .NB_COL(NCOL),
                        .TAG_WIDTH(TW)) bus ();

  operand_fetch_2r #(.SIZE(SIZE), .ADDR_WIDTH(AW), .COL_WIDTH(COLW),
                     .NB_COL(NCOL), .TAG_WIDTH(TW)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- write-first bank model ----------------
  logic [W-1:0] mem [SIZE];

  function automatic logic [W-1:0] wf_read(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = mem[a];
    if (a == bus.write_address) begin
      for (int c = 0; c < NCOL; c++)
        if (bus.write_enable[c]) v[c*COLW +: COLW] = bus.write_data[c*COLW +: COLW];
    end
    return v;
  endfunction

  always_ff @(posedge clock) begin
    for (int c = 0; c < NCOL; c++)
      if (bus.write_enable[c])
        mem[bus.write_address][c*COLW +: COLW] <= bus.write_data[c*COLW +: COLW];
    if (bus.read1_enable) bus.read1_data <= wf_read(bus.read1_address);
    if (bus.read2_enable) bus.read2_data <= wf_read(bus.read2_address);
  end

  // ---------------- checking infrastructure ----------------
  typedef struct packed {
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [TW-1:0] tag;
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
  } vec_t;

  exp_t sb_q[$];
  exp_t next_exp;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Sample at the falling edge: score any output handshake, then record the
  // expectation for a request accepted this cycle.
  task automatic sample();
    exp_t e;
    @(negedge clock);
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: output handshake tag %0d with no pending request", bus.out_tag);
      end else begin
        e = sb_q.pop_front();
        check("sb_data1", bus.out_data1, e.d1);
        check("sb_data2", bus.out_data2, e.d2);
        check("sb_tag", 32'(bus.out_tag), 32'(e.tag));
      end
    end
    if (bus.req_valid && bus.req_ready) sb_q.push_back(next_exp);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [TW-1:0] tag, input logic [W-1:0] d1,
                           input logic [W-1:0] d2);
    bus.req_valid    = 1'b1;
    bus.req_address1 = a1;
    bus.req_address2 = a2;
    bus.req_tag      = tag;
    next_exp         = '{d1: d1, d2: d2, tag: tag};
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
  endtask

  task automatic drive_write(input logic [NCOL-1:0] en, input logic [AW-1:0] a,
                             input logic [W-1:0] d);
    bus.write_enable  = en;
    bus.write_address = a;
    bus.write_data    = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a1: 10'd3, a2: 10'd5,    tag: 6'd1, d1: 32'h11111111, d2: 32'h22222222};
    vecs[1] = '{a1: 10'd5, a2: 10'd3,    tag: 6'd2, d1: 32'h22222222, d2: 32'h11111111};
    vecs[2] = '{a1: 10'd3, a2: 10'd3,    tag: 6'd3, d1: 32'h11111111, d2: 32'h11111111};
    vecs[3] = '{a1: 10'd0, a2: 10'd1023, tag: 6'd4, d1: 32'hA5A5A5A5, d2: 32'hCAFEF00D};
    vecs[4] = '{a1: 10'd7, a2: 10'd5,    tag: 6'd5, d1: 32'h77777777, d2: 32'h22222222};

    resetn           = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_address1 = '0;
    bus.req_address2 = '0;
    bus.req_tag      = '0;
    bus.out_ready    = 1'b0;
    drive_write('0, '0, '0);
    next_exp = '0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data1", bus.out_data1, 32'h0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    advance();

    // Preload the bank through its write port
    drive_write(4'hF, 10'd3,    32'h11111111); advance();
    drive_write(4'hF, 10'd5,    32'h22222222); advance();
    drive_write(4'hF, 10'd7,    32'h77777777); advance();
    drive_write(4'hF, 10'd0,    32'hA5A5A5A5); advance();
    drive_write(4'hF, 10'd1023, 32'hCAFEF00D); advance();
    drive_write('0, '0, '0);

    // Back-to-back streaming from the vector table
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(vecs[i].a1, vecs[i].a2, vecs[i].tag, vecs[i].d1, vecs[i].d2);
      sample();
      check("stream_req_ready", 32'(bus.req_ready), 32'd1);
      check("stream_rd1_en", 32'(bus.read1_enable), 32'd1);
      check("stream_rd2_addr", 32'(bus.read2_address), 32'(vecs[i].a2));
      if (i > 0) check("stream_out_valid", 32'(bus.out_valid), 32'd1);
      advance();
    end
    idle_req();
    sample();
    check("stream_last_valid", 32'(bus.out_valid), 32'd1);
    advance();
    sample();
    check("stream_drained", 32'(bus.out_valid), 32'd0);
    advance();

    // Stall and hold with a second request waiting
    bus.out_ready = 1'b0;
    drive_req(10'd3, 10'd5, 6'd9, 32'h11111111, 32'h22222222);
    sample();
    advance();
    drive_req(10'd7, 10'd0, 6'd10, 32'h77777777, 32'hA5A5A5A5);
    for (int k = 0; k < 3; k++) begin
      sample();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_data1", bus.out_data1, 32'h11111111);
      check("stall_data2", bus.out_data2, 32'h22222222);
      check("stall_tag", 32'(bus.out_tag), 32'd9);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_no_read", 32'(bus.read1_enable | bus.read2_enable), 32'd0);
      advance();
    end
    bus.out_ready = 1'b1;
    sample();
    check("stall_release_ready", 32'(bus.req_ready), 32'd1);
    check("stall_release_read", 32'(bus.read1_enable), 32'd1);
    advance();
    idle_req();
    sample();
    advance();

    // Merge while held (plus a disabled write that must not merge)
    bus.out_ready = 1'b0;
    drive_req(10'd3, 10'd5, 6'd11, 32'h11111111, 32'h2222CC22);
    sample();
    advance();
    idle_req();
    drive_write(4'b0000, 10'd5, 32'hFFFFFFFF);
    sample();
    advance();
    drive_write(4'b0010, 10'd5, 32'hAABBCCDD);
    sample();
    check("held_no_merge_we0", bus.out_data2, 32'h22222222);
    advance();
    drive_write('0, '0, '0);
    sample();
    check("held_merge_d2", bus.out_data2, 32'h2222CC22);
    check("held_merge_d1", bus.out_data1, 32'h11111111);
    advance();
    bus.out_ready = 1'b1;
    sample();
    advance();

    // Merge during the FRESH cycle
    bus.out_ready = 1'b0;
    drive_req(10'd3, 10'd5, 6'd12, 32'hDEADBEEF, 32'h2222CC22);
    sample();
    advance();
    idle_req();
    drive_write(4'hF, 10'd3, 32'hDEADBEEF);
    sample();
    check("fresh_pre_merge_d1", bus.out_data1, 32'h11111111);
    advance();
    drive_write('0, '0, '0);
    bus.out_ready = 1'b1;
    sample();
    check("fresh_merge_d1", bus.out_data1, 32'hDEADBEEF);
    advance();

    // Write in the issue cycle is seen through the write-first bank; a write
    // in the handshake cycle is not reflected.
    drive_req(10'd3, 10'd5, 6'd13, 32'h12345678, 32'h2222CC22);
    drive_write(4'hF, 10'd3, 32'h12345678);
    sample();
    advance();
    idle_req();
    drive_write(4'hF, 10'd5, 32'h55555555);
    sample();
    check("issue_write_d1", bus.out_data1, 32'h12345678);
    check("handshake_write_d2", bus.out_data2, 32'h2222CC22);
    advance();
    drive_write('0, '0, '0);

    // Asynchronous reset while HELD
    bus.out_ready = 1'b0;
    drive_req(10'd3, 10'd5, 6'd14, 32'h12345678, 32'h55555555);
    sample();
    advance();
    idle_req();
    sample();
    advance();
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    drive_req(10'd7, 10'd0, 6'd20, 32'h77777777, 32'hA5A5A5A5);
    resetn = 1'b0;
    #1;
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_data1", bus.out_data1, 32'h0);
    check("reset_data2", bus.out_data2, 32'h0);
    check("reset_tag", 32'(bus.out_tag), 32'd0);
    check("reset_no_read", 32'(bus.read1_enable | bus.read2_enable), 32'd0);
    check("reset_pending", 32'(sb_q.size()), 32'd1);
    sb_q.delete();
    idle_req();
    bus.out_ready = 1'b1;
    sample();
    advance();
    resetn = 1'b1;
    drive_req(10'd7, 10'd0, 6'd15, 32'h77777777, 32'hA5A5A5A5);
    sample();
    check("post_reset_read", 32'(bus.read1_enable), 32'd1);
    advance();
    idle_req();
    sample();
    check("post_reset_latency", 32'(bus.out_valid), 32'd1);
    advance();

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
